// File: rtl/uart_rx_oversampled_if.sv
// ============================================================================
// Module  : uart_rx_oversampled_if
// Brief   : Received-word handshake and error-pulse bundle for the UART receiver.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface uart_rx_oversampled_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 overrun;
  logic                 parity_err;

  modport master (
    output rx_data,
    output rx_valid,
    output frame_err,
    output overrun,
    output parity_err,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  overrun,
    input  parity_err,
    output rx_ready
  );
endinterface

`default_nettype wire

// File: rtl/uart_rx_oversampled.sv
// ============================================================================
// Module  : uart_rx_oversampled
// Brief   : 16x-oversampled UART receiver, mid-bit sampling, LSB-first deframing,
//           valid/ready output with frame-error/overrun (optional even parity via
//           macro UART_RX_PARITY_EN).
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_rx_oversampled #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_tick,
  input  logic                   rx,
  uart_rx_oversampled_if.master  rx_if
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_END  = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd4;
  localparam logic [2:0] S_BREAK = 3'd5;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY     = 3'd3;
  localparam logic [2:0] S_AFTER_DATA = S_PARITY;
`else
  localparam logic [2:0] S_AFTER_DATA = S_STOP;
`endif

  logic                 rx_meta_q;
  logic                 rx_s_q;
  logic [2:0]           state_q,  state_d;
  logic [CW-1:0]        cnt_q,    cnt_d;
  logic [BW-1:0]        bit_q,    bit_d;
  logic [DATA_BITS-1:0] shift_q,  shift_d;
  logic [DATA_BITS-1:0] data_q,   data_d;
  logic                 valid_q,  valid_d;
  logic                 fe_q,     fe_d;
  logic                 ov_q,     ov_d;
  logic                 w_deliver;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q, par_bad_d;
  logic                 pe_q,      pe_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q & ~rx_if.rx_ready;
    fe_d      = 1'b0;
    ov_d      = 1'b0;
    w_deliver = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    pe_d      = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (s_tick) begin
          if (cnt_q == CNT_MID) begin
            // A start bit that is high again at mid-bit was a glitch.
            if (!rx_s_q) begin
              state_d = S_DATA;
              cnt_d   = '0;
              bit_d   = '0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (s_tick) begin
          if (cnt_q == CNT_END) begin
            cnt_d   = '0;
            shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
            bit_d   = bit_q + 1'b1;
            if (bit_q == BIT_LAST) begin
              state_d = S_AFTER_DATA;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (s_tick) begin
          if (cnt_q == CNT_END) begin
            cnt_d     = '0;
            par_bad_d = rx_s_q ^ (^shift_q);
            state_d   = S_STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
`endif
      S_STOP: begin
        if (s_tick) begin
          if (cnt_q == CNT_END) begin
            cnt_d = '0;
            if (rx_s_q) begin
              w_deliver = 1'b1;
              state_d   = S_IDLE;
`ifdef UART_RX_PARITY_EN
              pe_d      = par_bad_q;
`endif
            end else begin
              fe_d    = 1'b1;
              state_d = S_BREAK;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_BREAK: begin
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // An unaccepted word blocks the new one unless it is consumed this very cycle.
    if (w_deliver) begin
      if (valid_q && !rx_if.rx_ready) begin
        ov_d = 1'b1;
      end else begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
      pe_q      <= 1'b0;
`endif
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      fe_q      <= fe_d;
      ov_q      <= ov_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
      pe_q      <= pe_d;
`endif
    end
  end

  assign rx_if.rx_data   = data_q;
  assign rx_if.rx_valid  = valid_q;
  assign rx_if.frame_err = fe_q;
  assign rx_if.overrun   = ov_q;
`ifdef UART_RX_PARITY_EN
  assign rx_if.parity_err = pe_q;
`else
  assign rx_if.parity_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_oversampled.sv
// ============================================================================
// Module  : tb_uart_rx_oversampled
// Brief   : Scoreboard bench for uart_rx_oversampled (directed + random frames).
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rx_oversampled;

  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;
  localparam int TICK_DIV   = 4;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic s_tick = 1'b0;
  logic rx     = 1'b1;

  uart_rx_oversampled_if #(.DATA_BITS(DATA_BITS)) u_if ();

  uart_rx_oversampled #(
    .DATA_BITS  (DATA_BITS),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .s_tick (s_tick),
    .rx     (rx),
    .rx_if  (u_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];
  int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0;
  int exp_fe = 0, exp_ov = 0, exp_pe = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Baud-tick source: one clk-wide pulse every TICK_DIV clocks.
  initial begin
    forever begin
      repeat (TICK_DIV - 1) @(posedge clk);
      #1 s_tick = 1'b1;
      @(posedge clk);
      #1 s_tick = 1'b0;
    end
  end

  task automatic wait_tick();
    do @(posedge clk); while (s_tick !== 1'b1);
  endtask

  task automatic hold(input logic v, input int nt);
    rx = v;
    repeat (nt) wait_tick();
    #1;
  endtask

  // Reference: a frame with a good stop bit yields the word (or an overrun if a
  // word is still waiting with the consumer stalled); a bad stop bit yields one frame error.
  task automatic send_frame(input logic [7:0] d, input logic par_bit, input logic stop_bit);
    if (stop_bit) begin
      if (u_if.rx_ready == 1'b0 && exp_q.size() != 0) exp_ov++;
      else exp_q.push_back(d);
`ifdef UART_RX_PARITY_EN
      if (par_bit != ^d) exp_pe++;
`endif
    end else begin
      exp_fe++;
    end
    hold(1'b0, OVERSAMPLE);
    for (int i = 0; i < DATA_BITS; i++) hold(d[i], OVERSAMPLE);
`ifdef UART_RX_PARITY_EN
    hold(par_bit, OVERSAMPLE);
`endif
    hold(stop_bit, OVERSAMPLE);
  endtask

  task automatic check_counts(input string tag);
    @(negedge clk);
    check({tag, "_frame_err_cnt"},  fe_cnt, exp_fe);
    check({tag, "_overrun_cnt"},    ov_cnt, exp_ov);
    check({tag, "_parity_err_cnt"}, pe_cnt, exp_pe);
    check({tag, "_pending_words"},  exp_q.size(), 0);
  endtask

  // Monitor: pops the scoreboard on every accepted word and counts error pulses.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (u_if.frame_err)  fe_cnt++;
        if (u_if.overrun)    ov_cnt++;
        if (u_if.parity_err) pe_cnt++;
        if (u_if.rx_valid && u_if.rx_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_word: got %02h expected none", u_if.rx_data);
          end else begin
            check("rx_data", u_if.rx_data, exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic       pb;
    logic       sb;
    u_if.rx_ready = 1'b1;

    #12;
    check("reset_rx_valid",   u_if.rx_valid,   0);
    check("reset_rx_data",    u_if.rx_data,    0);
    check("reset_frame_err",  u_if.frame_err,  0);
    check("reset_overrun",    u_if.overrun,    0);
    check("reset_parity_err", u_if.parity_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_tick();
    hold(1'b1, 4);

    // Basic frame
    send_frame(8'h55, ^8'h55, 1'b1);
    hold(1'b1, 4);
    check_counts("f55");

    // Short low glitch must be rejected
    hold(1'b0, 4);
    hold(1'b1, 24);
    check_counts("glitch");

    // Bad stop bit with the line held low, then a clean frame
    send_frame(8'hA3, ^8'hA3, 1'b0);
    hold(1'b0, 40);
    hold(1'b1, 4);
    check_counts("break");
    send_frame(8'h3C, ^8'h3C, 1'b1);
    hold(1'b1, 4);
    check_counts("f3c");

    // Overrun with the consumer stalled
    @(posedge clk); #1 u_if.rx_ready = 1'b0;
    send_frame(8'h11, ^8'h11, 1'b1);
    hold(1'b1, 2);
    send_frame(8'h22, ^8'h22, 1'b1);
    hold(1'b1, 4);
    @(negedge clk);
    check("ovr_rx_valid", u_if.rx_valid, 1);
    check("ovr_rx_data",  u_if.rx_data,  8'h11);
    check("ovr_count",    ov_cnt,        exp_ov);
    @(posedge clk); #1 u_if.rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("ovr_valid_drop", u_if.rx_valid, 0);
    check_counts("ovr");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b0, 1'b1);
    hold(1'b1, 4);
    check_counts("par_bad");
    send_frame(8'h07, 1'b1, 1'b1);
    hold(1'b1, 4);
    check_counts("par_good");
`endif

    // Reset during data bit 4 of 0xFF while an earlier word is still pending
    @(posedge clk); #1 u_if.rx_ready = 1'b0;
    send_frame(8'h5A, ^8'h5A, 1'b1);
    hold(1'b1, 4);
    @(negedge clk);
    check("pre_rst_valid", u_if.rx_valid, 1);
    hold(1'b0, OVERSAMPLE);
    for (int i = 0; i < 4; i++) hold(1'b1, OVERSAMPLE);
    hold(1'b1, OVERSAMPLE / 2);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", u_if.rx_valid,  0);
    check("async_rst_data",  u_if.rx_data,   0);
    check("async_rst_fe",    u_if.frame_err, 0);
    check("async_rst_ov",    u_if.overrun,   0);
    exp_q.delete();
    u_if.rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_tick();
    hold(1'b1, 4);
    send_frame(8'h81, ^8'h81, 1'b1);
    hold(1'b1, 4);
    check_counts("post_rst");

    // Random frames: random data, gaps, occasional bad stop / bad parity
    for (int k = 0; k < 24; k++) begin
      d  = 8'($urandom);
      sb = ($urandom_range(0, 7) != 0);
      pb = ($urandom_range(0, 3) == 0) ? ~(^d) : ^d;
      send_frame(d, pb, sb);
      if (!sb) hold(1'b0, $urandom_range(5, 40));
      hold(1'b1, $urandom_range(1, 20));
    end
    hold(1'b1, 4);
    check_counts("random");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
